uart_reg_bridge: RTL and testbench

- Host-command engine on the byte side of the UART core: consumes received bytes (rx2data/rx2next), decodes a 2–3 byte binary command, performs one register read or write on a simple internal register bus, and returns a one-byte response through the transmit interface (data2tx/next2tx/tx_busy).
- Gives an external host register-level access through the existing serial link.

---
 rtl/uart_reg_bridge_if.sv | 37 +++
 rtl/uart_reg_bridge.sv | 153 +++++++++++++++
 tb/tb_uart_reg_bridge.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_reg_bridge_if.sv
// uart_reg_bridge_if: byte-stream, transmit-request and register-bus signals
// of the UART host-command bridge, bundled as one interface.
//   rx_data_i / rx_valid_i : received byte and its one-cycle strobe
//   tx_data_o / tx_next_o  : response byte and one-cycle transmit request
//   tx_busy_i              : transmitter busy
//   reg_*                  : simple register bus (addr, wdata, we, re, rdata)
//   busy_o / timeout_o / overrun_o : bridge status
// Signal suffixes are from the bridge's point of view (modport slave).
interface uart_reg_bridge_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [7:0]        rx_data_i;
  logic              rx_valid_i;
  logic [7:0]        tx_data_o;
  logic              tx_next_o;
  logic              tx_busy_i;
  logic [ADDR_W-1:0] reg_addr_o;
  logic [7:0]        reg_wdata_o;
  logic              reg_we_o;
  logic              reg_re_o;
  logic [7:0]        reg_rdata_i;
  logic              busy_o;
  logic              timeout_o;
  logic              overrun_o;

  modport slave (
    input  rx_data_i, rx_valid_i, tx_busy_i, reg_rdata_i,
    output tx_data_o, tx_next_o, reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o,
           busy_o, timeout_o, overrun_o
  );

  modport master (
    output rx_data_i, rx_valid_i, tx_busy_i, reg_rdata_i,
    input  tx_data_o, tx_next_o, reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o,
           busy_o, timeout_o, overrun_o
  );
endinterface

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: decodes 2-3 byte binary host commands arriving from the
// UART receiver, performs one register write (01 addr data) or read
// (02 addr) on the internal register bus and returns a one-byte response
// (ACK_BYTE, read data, or NAK_BYTE for an unknown opcode) via the
// transmitter.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : uart_reg_bridge_if.slave (rx byte stream, tx request, register
//          bus, busy/timeout/overrun status)
module uart_reg_bridge #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  ACK_BYTE    = 8'hAA,
  parameter logic [7:0]  NAK_BYTE    = 8'hEE
) (
  input logic              clk,
  input logic              rst,
  uart_reg_bridge_if.slave bus
);

  localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]        OP_WR    = 8'h01;
  localparam logic [7:0]        OP_RD    = 8'h02;

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_CAP, SEND, TX_WAIT
  } state_e;

  state_e            state_q;
  logic              is_wr_q;
  logic [7:0]        resp_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic              we_q;
  logic              re_q;
  logic              timeout_q;
  logic              overrun_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        guard_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      is_wr_q   <= 1'b0;
      resp_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      cnt_q     <= '0;
      guard_q   <= '0;
    end else begin
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      timeout_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.rx_valid_i) begin
            cnt_q <= '0;
            if (bus.rx_data_i == OP_WR || bus.rx_data_i == OP_RD) begin
              is_wr_q <= (bus.rx_data_i == OP_WR);
              state_q <= GET_ADDR;
            end else begin
              resp_q  <= NAK_BYTE;
              state_q <= SEND;
            end
          end
        end
        GET_ADDR: begin
          if (bus.rx_valid_i) begin
            addr_q <= bus.rx_data_i[ADDR_W-1:0];
            cnt_q  <= '0;
            if (is_wr_q) begin
              state_q <= GET_DATA;
            end else begin
              re_q    <= 1'b1;
              state_q <= BUS_RD;
            end
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GET_DATA: begin
          if (bus.rx_valid_i) begin
            wdata_q <= bus.rx_data_i;
            cnt_q   <= '0;
            we_q    <= 1'b1;
            state_q <= BUS_WR;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        // Strobes are set on entry so they are high for exactly the
        // BUS_WR / BUS_RD cycle.
        BUS_WR: begin
          resp_q  <= ACK_BYTE;
          state_q <= SEND;
        end
        BUS_RD: state_q <= RD_CAP;
        RD_CAP: begin
          resp_q  <= bus.reg_rdata_i;
          state_q <= SEND;
        end
        SEND: begin
          if (!bus.tx_busy_i) begin
            guard_q <= '0;
            state_q <= TX_WAIT;
          end
        end
        // Two guard cycles ignore tx_busy_i while the transmitter picks up
        // the request; from the third cycle on, wait for it to go idle.
        TX_WAIT: begin
          if (guard_q != 2'd2) begin
            guard_q <= guard_q + 1'b1;
          end else if (!bus.tx_busy_i) begin
            state_q <= IDLE;
          end
        end
      endcase

      if (bus.rx_valid_i &&
          (state_q inside {BUS_WR, BUS_RD, RD_CAP, SEND, TX_WAIT})) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // tx_next_o follows the live tx_busy_i so the request is issued in the
  // same cycle the transmitter becomes free.
  assign bus.tx_next_o   = (state_q == SEND) && !bus.tx_busy_i;
  assign bus.tx_data_o   = resp_q;
  assign bus.reg_addr_o  = addr_q;
  assign bus.reg_wdata_o = wdata_q;
  assign bus.reg_we_o    = we_q;
  assign bus.reg_re_o    = re_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.timeout_o   = timeout_q;
  assign bus.overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb_uart_reg_bridge: builds a cycle timeline of stimulus and expected
// outputs from the command rules (byte gaps, latencies, back-pressure,
// guard, timeout, overrun), drives it into uart_reg_bridge and compares
// every cycle; then exercises asynchronous reset mid-command.
module tb_uart_reg_bridge;
  localparam int unsigned T = 100;
  localparam int N = 16384;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_reg_bridge_if #(.ADDR_W(8)) bus ();

  uart_reg_bridge #(
    .ADDR_W(8), .TIMEOUT_CYC(T), .ACK_BYTE(8'hAA), .NAK_BYTE(8'hEE)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int checks = 0;
  int failures = 0;

  bit         drv_valid [N];
  logic [7:0] drv_data  [N];
  bit         drv_busy  [N];
  bit         e_busy [N];
  bit         e_we   [N];
  bit         e_re   [N];
  bit         e_txn  [N];
  bit         e_to   [N];
  logic [7:0] e_addr [N];
  logic [7:0] e_wdata[N];
  logic [7:0] e_txd  [N];
  int         ovr_from;
  int         t;
  int         n_run;

  logic [7:0] mem     [256];
  logic [7:0] exp_mem [256];

  task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, k, act, exp);
    end
  endtask

  // Plan one command starting at idle cycle t. cut < command length sends
  // only the first cut bytes, so the command must time out.
  task automatic plan_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                          input int g1, input int g2, input int cut, input int hold,
                          input int dtx, input int xoff, input logic [7:0] xb, input int idle_gap);
    int p[3];
    logic [7:0] by[3];
    int full, nb, lb, e, s, c, x;
    logic [7:0] resp;
    by[0] = op; by[1] = a; by[2] = d;
    full = (op == 8'h01) ? 3 : (op == 8'h02) ? 2 : 1;
    nb = (cut < full) ? cut : full;
    p[0] = t; p[1] = t + g1; p[2] = p[1] + g2;
    for (int i = 0; i < nb; i++) begin
      drv_valid[p[i]] = 1'b1;
      drv_data[p[i]]  = by[i];
    end
    lb = p[nb-1];
    if (nb < full) begin
      for (int k = t + 1; k <= lb + int'(T); k++) e_busy[k] = 1'b1;
      e_to[lb + int'(T) + 1] = 1'b1;
      t = lb + int'(T) + 1 + idle_gap;
      return;
    end
    if (op == 8'h01) begin
      e_we[lb+1] = 1'b1; e_addr[lb+1] = a; e_wdata[lb+1] = d;
      exp_mem[a] = d;
      e = lb + 2; resp = 8'hAA;
    end else if (op == 8'h02) begin
      e_re[lb+1] = 1'b1; e_addr[lb+1] = a;
      e = lb + 3; resp = exp_mem[a];
    end else begin
      e = lb + 1; resp = 8'hEE;
    end
    s = e + hold;
    if (hold > 0) for (int k = t; k < s; k++) drv_busy[k] = 1'b1;
    e_txn[s] = 1'b1; e_txd[s] = resp;
    for (int k = s + 1; k <= s + dtx; k++) drv_busy[k] = 1'b1;
    c = (s + 3 > s + dtx + 1) ? s + 3 : s + dtx + 1;
    for (int k = t + 1; k <= c; k++) e_busy[k] = 1'b1;
    if (xoff != -2) begin
      x = (xoff < 0) ? lb + 1 + $urandom_range(0, c - lb - 1) : lb + 1 + xoff;
      if (x > c) x = c;
      drv_valid[x] = 1'b1; drv_data[x] = xb;
      if (x + 1 < ovr_from) ovr_from = x + 1;
    end
    t = c + 1 + idle_gap;
  endtask

  function automatic int pick_gap();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return int'(T);
    if (r < 10) return 1;
    return $urandom_range(2, 8);
  endfunction

  task automatic step(input logic v, input logic [7:0] dd, input logic b);
    @(posedge clk); #1;
    bus.rx_valid_i = v; bus.rx_data_i = dd; bus.tx_busy_i = b;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  0, {7'd0, bus.busy_o},    8'h00);
    chk({tag, "_we"},    0, {7'd0, bus.reg_we_o},  8'h00);
    chk({tag, "_re"},    0, {7'd0, bus.reg_re_o},  8'h00);
    chk({tag, "_txn"},   0, {7'd0, bus.tx_next_o}, 8'h00);
    chk({tag, "_to"},    0, {7'd0, bus.timeout_o}, 8'h00);
    chk({tag, "_ovr"},   0, {7'd0, bus.overrun_o}, 8'h00);
    chk({tag, "_txd"},   0, bus.tx_data_o,         8'h00);
    chk({tag, "_addr"},  0, bus.reg_addr_o,        8'h00);
    chk({tag, "_wdata"}, 0, bus.reg_wdata_o,       8'h00);
  endtask

  // Register-bus slave: read data valid the cycle after reg_re_o, junk otherwise.
  initial begin
    logic re_s, we_s;
    logic [7:0] a_s, d_s;
    bus.reg_rdata_i = '0;
    forever begin
      @(negedge clk);
      re_s = bus.reg_re_o; we_s = bus.reg_we_o; a_s = bus.reg_addr_o; d_s = bus.reg_wdata_o;
      @(posedge clk); #1;
      bus.reg_rdata_i = re_s ? mem[a_s] : 8'($urandom);
      if (we_s) mem[a_s] = d_s;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_at, txn_at, re_seen;
    logic [7:0] txd_at, wa_at, wd_at;
    logic [7:0] op;
    rst = 1'b0;
    bus.rx_valid_i = 1'b0; bus.rx_data_i = '0; bus.tx_busy_i = 1'b0;
    for (int i = 0; i < 256; i++) begin
      exp_mem[i] = 8'($urandom);
    end
    exp_mem[8'h10] = 8'hC3;
    for (int i = 0; i < 256; i++) mem[i] = exp_mem[i];
    for (int k = 0; k < N; k++) begin
      drv_valid[k] = 1'b0; drv_data[k] = 8'($urandom); drv_busy[k] = 1'b0;
      e_busy[k] = 1'b0; e_we[k] = 1'b0; e_re[k] = 1'b0; e_txn[k] = 1'b0; e_to[k] = 1'b0;
      e_addr[k] = '0; e_wdata[k] = '0; e_txd[k] = '0;
    end
    ovr_from = N + 1;

    // Directed commands first, then random ones.
    t = 2;
    plan_cmd(8'h01, 8'h34, 8'h5A, 1, 1, 3, 0, 3, -2, 8'h00, 0);
    plan_cmd(8'h02, 8'h10, 8'h00, 1, 1, 3, 0, 0, -2, 8'h00, 0);
    plan_cmd(8'h7F, 8'h00, 8'h00, 1, 1, 3, 0, 0, -2, 8'h00, 0);
    plan_cmd(8'h01, 8'h22, 8'h00, 1, 1, 2, 0, 0, -2, 8'h00, 0);
    plan_cmd(8'h02, 8'h22, 8'h00, 1, 1, 3, 0, 0, -2, 8'h00, 0);
    plan_cmd(8'h02, 8'h05, 8'h00, 1, 1, 3, 6, 2, 1, 8'h99, 1);

    // Hand-computed timeline points pinning the model.
    chk("pin_we",    5,   {7'd0, e_we[5]},   8'h01);
    chk("pin_waddr", 5,   e_addr[5],         8'h34);
    chk("pin_wdata", 5,   e_wdata[5],        8'h5A);
    chk("pin_ack",   6,   {7'd0, e_txn[6]},  8'h01);
    chk("pin_ackd",  6,   e_txd[6],          8'hAA);
    chk("pin_re",    13,  {7'd0, e_re[13]},  8'h01);
    chk("pin_rdd",   15,  e_txd[15],         8'hC3);
    chk("pin_nak",   20,  e_txd[20],         8'hEE);
    chk("pin_to",    126, {7'd0, e_to[126]}, 8'h01);
    chk("pin_tobsy", 126, {7'd0, e_busy[126]}, 8'h00);
    chk("pin_hold",  144, {7'd0, e_txn[144]}, 8'h01);
    chk("pin_ovr",   138, 8'(ovr_from),      8'd138);

    for (int n = 0; n < 150 && t < N - 400; n++) begin
      int kind;
      logic [7:0] a;
      kind = $urandom_range(0, 9);
      op = (kind < 4) ? 8'h01 : (kind < 8) ? 8'h02 : 8'($urandom_range(3, 255));
      a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      plan_cmd(op, a, 8'($urandom), pick_gap(), pick_gap(),
               ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 3,
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0,
               $urandom_range(0, 6),
               ($urandom_range(0, 5) == 0) ? -1 : -2,
               8'($urandom), $urandom_range(0, 2));
    end
    n_run = t + 8;

    #1 rst = 1'b1;
    #2 chk_all_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    fork
      begin
        for (int k = 0; k < n_run; k++) begin
          @(posedge clk); #1;
          bus.rx_valid_i = drv_valid[k]; bus.rx_data_i = drv_data[k]; bus.tx_busy_i = drv_busy[k];
        end
      end
      begin
        for (int k = 0; k < n_run; k++) begin
          @(posedge clk); @(negedge clk);
          chk("busy", k, {7'd0, bus.busy_o},    {7'd0, e_busy[k]});
          chk("we",   k, {7'd0, bus.reg_we_o},  {7'd0, e_we[k]});
          chk("re",   k, {7'd0, bus.reg_re_o},  {7'd0, e_re[k]});
          chk("txn",  k, {7'd0, bus.tx_next_o}, {7'd0, e_txn[k]});
          chk("to",   k, {7'd0, bus.timeout_o}, {7'd0, e_to[k]});
          chk("ovr",  k, {7'd0, bus.overrun_o}, {7'd0, 1'(k >= ovr_from)});
          if (e_we[k]) begin
            chk("waddr", k, bus.reg_addr_o,  e_addr[k]);
            chk("wdata", k, bus.reg_wdata_o, e_wdata[k]);
          end
          if (e_re[k]) chk("raddr", k, bus.reg_addr_o, e_addr[k]);
          if (e_txn[k]) chk("txd", k, bus.tx_data_o, e_txd[k]);
        end
      end
    join

    // Reset while waiting for the data byte.
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    #2 chk("getdata_busy", 0, {7'd0, bus.busy_o}, 8'h01);
    rst = 1'b1;
    #1 chk_all_zero("rst_getdata");
    @(negedge clk) rst = 1'b0;

    // Reset while a read response is held in SEND by tx_busy_i.
    step(1'b1, 8'h02, 1'b1);
    step(1'b1, 8'h07, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    #2;
    chk("send_busy", 0, {7'd0, bus.busy_o},    8'h01);
    chk("send_txn",  0, {7'd0, bus.tx_next_o}, 8'h00);
    chk("send_txd",  0, bus.tx_data_o,         exp_mem[7]);
    rst = 1'b1;
    #1 chk_all_zero("rst_send");
    @(negedge clk) rst = 1'b0;

    // A full write afterwards completes normally.
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    we_at = -1; txn_at = -1; re_seen = 0; txd_at = '0; wa_at = '0; wd_at = '0;
    for (int j = 1; j <= 8; j++) begin
      step(1'b0, 8'h00, 1'b0);
      #2;
      if (bus.reg_we_o && we_at < 0) begin
        we_at = j; wa_at = bus.reg_addr_o; wd_at = bus.reg_wdata_o;
      end
      if (bus.tx_next_o && txn_at < 0) begin
        txn_at = j; txd_at = bus.tx_data_o;
      end
      if (bus.reg_re_o) re_seen++;
    end
    chk("post_we_lat",  0, 8'(we_at),  8'd1);
    chk("post_waddr",   0, wa_at,      8'h01);
    chk("post_wdata",   0, wd_at,      8'h01);
    chk("post_txn_lat", 0, 8'(txn_at), 8'd2);
    chk("post_ack",     0, txd_at,     8'hAA);
    chk("post_no_re",   0, 8'(re_seen), 8'd0);
    chk("post_idle",    0, {7'd0, bus.busy_o}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
